// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage downstream of the EX/MEM latch.
//
// Consumes the latched ALU result, branch target, store data, rd and control
// signals, runs a req/ack transaction to data memory with a timeout, resolves
// branches and registers results into the MEM/WB outputs.
//
// Ports
//   clk, reset (async, active-low)
//   EX/MEM side : in_valid, br, br_cond, alu_cond, alu, adder, writedata, rd,
//                 signals ([0] mem_read, [1] mem_write, [2] reg_write,
//                 [3] mem_to_reg, [10:4] pass-through)
//   dmem side   : dmem_req, dmem_we, dmem_addr, dmem_wdata (out),
//                 dmem_ack, dmem_rdata (in)
//   hazard/pc   : stall, pc_src, br_target (combinational), flush (registered)
//   MEM/WB side : wb_valid, wb_alu, wb_rdata, wb_rd, wb_signals, mem_err
module mem_stage #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        br,
  input  logic [3:0]        br_cond,
  input  logic [3:0]        alu_cond,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] adder,
  input  logic [DATA_W-1:0] writedata,
  input  logic [3:0]        rd,
  input  logic [10:0]       signals,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] br_target,
  output logic              flush,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_alu,
  output logic [DATA_W-1:0] wb_rdata,
  output logic [3:0]        wb_rd,
  output logic [10:0]       wb_signals,
  output logic              mem_err
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_cap_alu;
  logic [3:0]          r_cap_rd;
  logic [10:0]         r_cap_sig;

  logic w_mem_op;
  logic w_timeout;
  logic w_taken;
  logic w_cap_read;

  assign w_mem_op  = in_valid & (signals[0] | signals[1]);
  assign w_timeout = (r_state == S_WAIT) & (r_cnt == LAST_CNT) & ~dmem_ack;
  // A request with both read and write set is a write, so it returns no data.
  assign w_cap_read = r_cap_sig[0] & ~r_cap_sig[1];

  // Branches resolve only for non-memory instructions accepted in IDLE.
  assign w_taken = (r_state == S_IDLE) & in_valid & ~w_mem_op &
                   ((br == 4'b0001) | ((br == 4'b0010) & (|(br_cond & alu_cond))));

  assign pc_src    = w_taken;
  assign br_target = adder;

  // Stall is masked while reset is held so upstream is released immediately
  // even though it may still be presenting the abandoned memory instruction.
  assign stall = reset & (((r_state == S_IDLE) & w_mem_op) |
                          ((r_state == S_WAIT) & ~dmem_ack & ~w_timeout));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cap_alu  <= '0;
      r_cap_rd   <= '0;
      r_cap_sig  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      flush      <= 1'b0;
      wb_valid   <= 1'b0;
      wb_alu     <= '0;
      wb_rdata   <= '0;
      wb_rd      <= '0;
      wb_signals <= '0;
      mem_err    <= 1'b0;
    end else begin
      flush   <= 1'b0;
      mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_state    <= S_WAIT;
            r_cnt      <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= signals[1];
            dmem_addr  <= alu;
            dmem_wdata <= writedata;
            r_cap_alu  <= alu;
            r_cap_rd   <= rd;
            r_cap_sig  <= signals;
            wb_valid   <= 1'b0;
          end else begin
            wb_valid   <= in_valid;
            wb_alu     <= alu;
            wb_rdata   <= '0;
            wb_rd      <= rd;
            wb_signals <= signals;
            flush      <= w_taken;
          end
        end
        S_WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (dmem_ack || (r_cnt == LAST_CNT)) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b1;
            wb_alu     <= r_cap_alu;
            wb_rd      <= r_cap_rd;
            if (dmem_ack) begin
              wb_rdata   <= w_cap_read ? dmem_rdata : '0;
              wb_signals <= r_cap_sig;
            end else begin
              // Abandoned access: suppress the register write-back.
              wb_rdata   <= '0;
              wb_signals <= {r_cap_sig[10:3], 1'b0, r_cap_sig[1:0]};
              mem_err    <= 1'b1;
            end
          end else begin
            r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            wb_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [3:0]        br, br_cond, alu_cond, rd;
  logic [DATA_W-1:0] alu, adder, writedata, dmem_rdata;
  logic [10:0]       signals;
  logic              dmem_req, dmem_we, dmem_ack;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, br_target;
  logic              stall, pc_src, flush, wb_valid, mem_err;
  logic [DATA_W-1:0] wb_alu, wb_rdata;
  logic [3:0]        wb_rd;
  logic [10:0]       wb_signals;

  int total = 0;
  int bad   = 0;
  int n;

  mem_stage #(.DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .br(br), .br_cond(br_cond),
    .alu_cond(alu_cond), .alu(alu), .adder(adder), .writedata(writedata),
    .rd(rd), .signals(signals), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .pc_src(pc_src),
    .br_target(br_target), .flush(flush), .wb_valid(wb_valid),
    .wb_alu(wb_alu), .wb_rdata(wb_rdata), .wb_rd(wb_rd),
    .wb_signals(wb_signals), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 0; br = 0; br_cond = 0; alu_cond = 0; rd = 0;
    alu = 0; adder = 0; writedata = 0; signals = 0; dmem_ack = 0; dmem_rdata = 0;
    tick(); tick();
    chk("rst_req", dmem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_flush", flush, 0);
    chk("rst_wbalu", wb_alu, 0);
    reset = 1'b1;
    tick();

    // ALU op
    in_valid = 1; alu = 32'h1234; rd = 5; signals = 11'h004; #1;
    chk("alu_stall", stall, 0);
    chk("alu_pcsrc", pc_src, 0);
    tick();
    chk("alu_wbalu", wb_alu, 32'h1234);
    chk("alu_wbrd", wb_rd, 5);
    chk("alu_wbv", wb_valid, 1);
    chk("alu_wbsig", wb_signals, 11'h004);
    chk("alu_wbrdata", wb_rdata, 0);

    // Load, ack on the 4th WAIT cycle
    alu = 32'h100; rd = 7; signals = 11'h00D; #1;
    n = 0;
    if (stall) n++;
    tick();
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_wbv_wait", wb_valid, 0);
    for (int i = 0; i < 3; i++) begin
      if (stall) n++;
      tick();
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #1;
    chk("ld_stall_ack", stall, 0);
    chk("ld_stall_cycles", n, 4);
    tick();
    dmem_ack = 0; in_valid = 0;
    chk("ld_rdata", wb_rdata, 32'hDEADBEEF);
    chk("ld_wbv", wb_valid, 1);
    chk("ld_wbrd", wb_rd, 7);
    chk("ld_wbalu", wb_alu, 32'h100);
    chk("ld_req_off", dmem_req, 0);
    tick();
    chk("ld_wbv_drop", wb_valid, 0);

    // Store, ack on first WAIT cycle
    in_valid = 1; alu = 32'h40; writedata = 32'hA5A5A5A5; signals = 11'h002; #1;
    chk("st_stall_idle", stall, 1);
    tick();
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h40);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    dmem_ack = 1; #1;
    chk("st_stall_ack", stall, 0);
    tick();
    dmem_ack = 0; in_valid = 0;
    chk("st_wbv", wb_valid, 1);
    chk("st_we_off", dmem_we, 0);
    chk("st_req_off", dmem_req, 0);
    chk("st_rdata", wb_rdata, 0);

    // Load that times out
    in_valid = 1; alu = 32'h80; rd = 3; signals = 11'h00D;
    tick();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (dmem_req) n++;
      if (i == 14) chk("to_stall_pre", stall, 1);
      if (i == 15) begin
        chk("to_stall_last", stall, 0);
        in_valid = 0;
      end
      tick();
    end
    chk("to_req_cycles", n, 16);
    chk("to_req_off", dmem_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_wbv", wb_valid, 1);
    chk("to_wbsig", wb_signals, 11'h009);
    chk("to_rdata", wb_rdata, 0);
    chk("to_wbalu", wb_alu, 32'h80);
    tick();
    chk("to_err_pulse", mem_err, 0);
    chk("to_wbv_drop", wb_valid, 0);

    // Load acked on the final cycle: ack wins over timeout
    in_valid = 1; alu = 32'h84; signals = 11'h00D;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        dmem_ack = 1; dmem_rdata = 32'h11; in_valid = 0;
      end
      tick();
    end
    dmem_ack = 0;
    chk("late_err", mem_err, 0);
    chk("late_rdata", wb_rdata, 32'h11);
    chk("late_wbsig", wb_signals, 11'h00D);
    chk("late_wbv", wb_valid, 1);

    // Branches
    in_valid = 1; signals = 11'h000; br = 4'b0010; br_cond = 4'b0100;
    alu_cond = 4'b0100; adder = 32'h200; #1;
    chk("br_taken", pc_src, 1);
    chk("br_target", br_target, 32'h200);
    chk("br_flush_pre", flush, 0);
    tick();
    chk("br_flush", flush, 1);
    alu_cond = 4'b0000; #1;
    chk("br_not_taken", pc_src, 0);
    tick();
    chk("br_flush_clr", flush, 0);
    br = 4'b0001; #1;
    chk("br_uncond", pc_src, 1);
    signals = 11'h002; #1;
    chk("br_memop", pc_src, 0);
    chk("br_memop_stall", stall, 1);
    tick();
    chk("br_memop_flush", flush, 0);
    dmem_ack = 1;
    tick();
    dmem_ack = 0; in_valid = 0; br = 0;
    tick();

    // Reset in the middle of a transaction
    in_valid = 1; alu = 32'h300; signals = 11'h00D;
    tick();
    tick();
    chk("mr_req_pre", dmem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("mr_req", dmem_req, 0);
    chk("mr_wbv", wb_valid, 0);
    chk("mr_stall", stall, 0);
    in_valid = 0;
    tick();
    reset = 1'b1;
    tick();
    chk("mr_idle_req", dmem_req, 0);
    chk("mr_idle_wbv", wb_valid, 0);
    in_valid = 1; alu = 32'h55; rd = 9; signals = 11'h004; #1;
    chk("mr_idle_stall", stall, 0);
    tick();
    chk("mr_idle_alu", wb_alu, 32'h55);
    chk("mr_idle_wbv2", wb_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
